// File: rtl/branch_pkg.sv
// Shared types and helpers for the gshare branch resolution path.
package branch_pkg;

  localparam int BP_GHR_SIZE = 10;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   taken;
    logic [31:0]            target;
    logic [BP_GHR_SIZE-1:0] ghr;
    logic [1:0]             ctr;
  } bp_meta_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } brs_state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_meta_fifo.sv
// Circular FIFO of in-flight branch metadata with single-cycle flush.
module bp_meta_fifo
  import branch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  bp_meta_t      push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output bp_meta_t      head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  bp_meta_t      mem_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // NOTE: storage is deliberately not reset; head/tail/count alone decide which
  // entries are live, so reset only needs to clear the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + AW'(1);
      if (pop_i)  head_q <= head_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// gshare resolution: PHT write-back, mispredict detection, redirect and GHR restore.
// GHR_SIZE must match branch_pkg::BP_GHR_SIZE, which sizes the stored metadata.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter  int GHR_SIZE = BP_GHR_SIZE,
  parameter  int QDEPTH   = 8,
  localparam int CW       = $clog2(QDEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pred_valid,
  output logic                pred_ready,
  input  logic [31:0]         pred_pc,
  input  logic                pred_taken,
  input  logic [31:0]         pred_target,
  input  logic [GHR_SIZE-1:0] pred_ghr,
  input  logic [1:0]          pred_ctr,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic                res_taken,
  input  logic [31:0]         res_target,
  output logic                upd_valid,
  output logic [GHR_SIZE-1:0] upd_idx,
  output logic [1:0]          upd_ctr,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  output logic                ghr_restore_valid,
  output logic [GHR_SIZE-1:0] ghr_restore_value,
  output logic [CW-1:0]       q_count
);

  brs_state_t state_q;
  bp_meta_t   push_meta;
  bp_meta_t   head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  logic                mis_d;
  logic [GHR_SIZE-1:0] idx_d;
  logic [1:0]          ctr_d;
  logic [31:0]         redirect_pc_d;
  logic [GHR_SIZE-1:0] ghr_restore_d;

  logic                upd_valid_q;
  logic [GHR_SIZE-1:0] upd_idx_q;
  logic [1:0]          upd_ctr_q;
  logic                redirect_valid_q;
  logic [31:0]         redirect_pc_q;
  logic                ghr_restore_valid_q;
  logic [GHR_SIZE-1:0] ghr_restore_value_q;

  assign pred_ready = !full  && (state_q == IDLE);
  assign res_ready  = !empty && (state_q == IDLE);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid  && res_ready;

  assign push_meta = '{pc: pred_pc, taken: pred_taken, target: pred_target,
                       ghr: pred_ghr, ctr: pred_ctr};

  // Wrong-path entries (including one pushed alongside the mispredicting pop)
  // are dropped during the single RECOVER cycle.
  bp_meta_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_meta),
    .pop_i       (pop),
    .flush_i     (state_q == RECOVER),
    .head_o      (head),
    .count_o     (q_count),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign idx_d         = head.pc[GHR_SIZE-1:0] ^ head.ghr;
  assign ctr_d         = res_taken ? sat_inc(head.ctr) : sat_dec(head.ctr);
  assign mis_d         = (res_taken != head.taken) ||
                         (res_taken && head.taken && (res_target != head.target));
  assign redirect_pc_d = res_taken ? res_target : head.pc + 32'd4;
  assign ghr_restore_d = {head.ghr[GHR_SIZE-2:0], res_taken};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      upd_valid_q         <= 1'b0;
      upd_idx_q           <= '0;
      upd_ctr_q           <= '0;
      redirect_valid_q    <= 1'b0;
      redirect_pc_q       <= '0;
      ghr_restore_valid_q <= 1'b0;
      ghr_restore_value_q <= '0;
    end else begin
      upd_valid_q         <= pop;
      redirect_valid_q    <= pop && mis_d;
      ghr_restore_valid_q <= pop && mis_d;
      if (pop) begin
        upd_idx_q <= idx_d;
        upd_ctr_q <= ctr_d;
      end
      // Redirect payloads hold between pulses; consumers qualify with valid.
      if (pop && mis_d) begin
        redirect_pc_q       <= redirect_pc_d;
        ghr_restore_value_q <= ghr_restore_d;
      end
      unique case (state_q)
        IDLE:    state_q <= (pop && mis_d) ? RECOVER : IDLE;
        RECOVER: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd_valid         = upd_valid_q;
  assign upd_idx           = upd_idx_q;
  assign upd_ctr           = upd_ctr_q;
  assign redirect_valid    = redirect_valid_q;
  assign redirect_pc       = redirect_pc_q;
  assign ghr_restore_valid = ghr_restore_valid_q;
  assign ghr_restore_value = ghr_restore_value_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  localparam int GHR = 10;
  localparam int QD  = 8;
  localparam int CW  = $clog2(QD) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pred_valid = 1'b0;
  logic            pred_ready;
  logic [31:0]     pred_pc = '0;
  logic            pred_taken = 1'b0;
  logic [31:0]     pred_target = '0;
  logic [GHR-1:0]  pred_ghr = '0;
  logic [1:0]      pred_ctr = '0;
  logic            res_valid = 1'b0;
  logic            res_ready;
  logic            res_taken = 1'b0;
  logic [31:0]     res_target = '0;
  logic            upd_valid;
  logic [GHR-1:0]  upd_idx;
  logic [1:0]      upd_ctr;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            ghr_restore_valid;
  logic [GHR-1:0]  ghr_restore_value;
  logic [CW-1:0]   q_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.GHR_SIZE(GHR), .QDEPTH(QD)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pred_valid        (pred_valid),
    .pred_ready        (pred_ready),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .pred_ghr          (pred_ghr),
    .pred_ctr          (pred_ctr),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_taken         (res_taken),
    .res_target        (res_target),
    .upd_valid         (upd_valid),
    .upd_idx           (upd_idx),
    .upd_ctr           (upd_ctr),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .ghr_restore_valid (ghr_restore_valid),
    .ghr_restore_value (ghr_restore_value),
    .q_count           (q_count)
  );

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pred(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic [GHR-1:0] ghr, input logic [1:0] ctr);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tgt;
    pred_ghr    = ghr;
    pred_ctr    = ctr;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic [GHR-1:0] ghr, input logic [1:0] ctr);
    set_pred(pc, tk, tgt, ghr, ctr);
    do_cycle();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_taken  = tk;
    res_target = tgt;
    do_cycle();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (q_count !== '0) $display("FAIL reset_qcount got %0d want 0", q_count); else n_pass++;
    n_total++;
    if ({upd_valid, redirect_valid, ghr_restore_valid} !== 3'b000)
      $display("FAIL reset_valids got %b want 000", {upd_valid, redirect_valid, ghr_restore_valid});
    else n_pass++;
    n_total++;
    if (upd_idx !== '0 || upd_ctr !== '0 || redirect_pc !== '0 || ghr_restore_value !== '0)
      $display("FAIL reset_payload got idx=%h ctr=%h rpc=%h ghr=%h want all 0",
               upd_idx, upd_ctr, redirect_pc, ghr_restore_value);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    do_cycle();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i) * 4, 1'b0, 32'h0, '0, 2'd1);
    resolve(1'b0, 32'h0);
    n_total++; if (q_count !== CW'(3)) $display("FAIL mid_pre_qcount got %0d want 3", q_count); else n_pass++;
    n_total++; if (upd_valid !== 1'b1) $display("FAIL mid_pre_upd got %b want 1", upd_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (q_count !== '0) $display("FAIL mid_rst_qcount got %0d want 0", q_count); else n_pass++;
    n_total++;
    if ({upd_valid, redirect_valid, ghr_restore_valid} !== 3'b000)
      $display("FAIL mid_rst_valids got %b want 000", {upd_valid, redirect_valid, ghr_restore_valid});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    do_cycle();
  endtask

  task automatic test_correct();
    push(32'h100, 1'b1, 32'h200, 10'h3FF, 2'd2);
    resolve(1'b1, 32'h200);
    n_total++; if (upd_valid !== 1'b1) $display("FAIL corr_upd_valid got %b want 1", upd_valid); else n_pass++;
    n_total++; if (upd_idx !== 10'h2FF) $display("FAIL corr_idx got %h want 2ff", upd_idx); else n_pass++;
    n_total++; if (upd_ctr !== 2'd3) $display("FAIL corr_ctr got %0d want 3", upd_ctr); else n_pass++;
    n_total++;
    if (redirect_valid !== 1'b0 || ghr_restore_valid !== 1'b0)
      $display("FAIL corr_noredir got rv=%b gv=%b want 0 0", redirect_valid, ghr_restore_valid);
    else n_pass++;
    do_cycle();
    n_total++; if (upd_valid !== 1'b0) $display("FAIL corr_upd_pulse got %b want 0", upd_valid); else n_pass++;
  endtask

  task automatic test_saturation();
    push(32'h20, 1'b1, 32'h60, '0, 2'd3);
    push(32'h24, 1'b0, 32'h0,  '0, 2'd0);
    push(32'h28, 1'b1, 32'h90, '0, 2'd1);
    resolve(1'b1, 32'h60);
    n_total++; if (upd_ctr !== 2'd3) $display("FAIL sat_hi got %0d want 3", upd_ctr); else n_pass++;
    n_total++; if (upd_idx !== 10'h020) $display("FAIL sat_idx got %h want 020", upd_idx); else n_pass++;
    resolve(1'b0, 32'h0);
    n_total++; if (upd_ctr !== 2'd0) $display("FAIL sat_lo got %0d want 0", upd_ctr); else n_pass++;
    resolve(1'b1, 32'h90);
    n_total++; if (upd_ctr !== 2'd2) $display("FAIL sat_inc got %0d want 2", upd_ctr); else n_pass++;
    n_total++; if (redirect_valid !== 1'b0) $display("FAIL sat_noredir got %b want 0", redirect_valid); else n_pass++;
    do_cycle();
  endtask

  task automatic test_direction_mispredict();
    push(32'h40, 1'b0, 32'h0, 10'h005, 2'd1);
    for (int i = 1; i < 4; i++) push(32'h40 + 32'(i) * 4, 1'b0, 32'h0, '0, 2'd1);
    n_total++; if (q_count !== CW'(4)) $display("FAIL dir_pre_qcount got %0d want 4", q_count); else n_pass++;
    set_pred(32'h60, 1'b0, 32'h0, '0, 2'd1);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h80;
    do_cycle();
    pred_valid = 1'b0; res_valid = 1'b0;
    n_total++; if (upd_valid !== 1'b1 || upd_idx !== 10'h045) $display("FAIL dir_upd got v=%b idx=%h want 1 045", upd_valid, upd_idx); else n_pass++;
    n_total++; if (upd_ctr !== 2'd2) $display("FAIL dir_ctr got %0d want 2", upd_ctr); else n_pass++;
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) $display("FAIL dir_redir got v=%b pc=%h want 1 80", redirect_valid, redirect_pc); else n_pass++;
    n_total++; if (ghr_restore_valid !== 1'b1 || ghr_restore_value !== 10'h00B) $display("FAIL dir_ghr got v=%b val=%h want 1 00b", ghr_restore_valid, ghr_restore_value); else n_pass++;
    n_total++; if (pred_ready !== 1'b0 || res_ready !== 1'b0) $display("FAIL dir_recover_ready got p=%b r=%b want 0 0", pred_ready, res_ready); else n_pass++;
    do_cycle();
    n_total++; if (q_count !== '0) $display("FAIL dir_flush got %0d want 0", q_count); else n_pass++;
    n_total++;
    if ({upd_valid, redirect_valid, ghr_restore_valid} !== 3'b000)
      $display("FAIL dir_pulse got %b want 000", {upd_valid, redirect_valid, ghr_restore_valid});
    else n_pass++;
    n_total++; if (redirect_pc !== 32'h80) $display("FAIL dir_hold got %h want 80", redirect_pc); else n_pass++;
    n_total++; if (pred_ready !== 1'b1) $display("FAIL dir_idle_ready got %b want 1", pred_ready); else n_pass++;
  endtask

  task automatic test_target_mispredict();
    push(32'h50, 1'b1, 32'h300, '0, 2'd2);
    resolve(1'b1, 32'h304);
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) $display("FAIL tgt_redir got v=%b pc=%h want 1 304", redirect_valid, redirect_pc); else n_pass++;
    n_total++; if (upd_ctr !== 2'd3 || ghr_restore_value !== 10'h001) $display("FAIL tgt_ctr_ghr got ctr=%0d ghr=%h want 3 001", upd_ctr, ghr_restore_value); else n_pass++;
    do_cycle();
    push(32'h1FC, 1'b1, 32'h400, '0, 2'd2);
    resolve(1'b0, 32'h0);
    n_total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) $display("FAIL rev_redir got v=%b pc=%h want 1 200", redirect_valid, redirect_pc); else n_pass++;
    n_total++; if (upd_ctr !== 2'd1 || ghr_restore_value !== 10'h000) $display("FAIL rev_ctr_ghr got ctr=%0d ghr=%h want 1 000", upd_ctr, ghr_restore_value); else n_pass++;
    do_cycle();
  endtask

  task automatic test_queue_limits();
    logic [31:0] exp_q[$];
    logic [31:0] pc;
    int          n = 0;
    for (int i = 0; i < QD; i++) begin
      pc = 32'h1000 + 32'(n) * 4; n++;
      push(pc, 1'b0, 32'h0, '0, 2'd1);
      exp_q.push_back(pc);
    end
    n_total++; if (q_count !== CW'(8) || pred_ready !== 1'b0) $display("FAIL q_full got cnt=%0d rdy=%b want 8 0", q_count, pred_ready); else n_pass++;
    push(32'hDEAD0, 1'b0, 32'h0, '0, 2'd1);
    n_total++; if (q_count !== CW'(8)) $display("FAIL q_nopush got %0d want 8", q_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pc = exp_q.pop_front();
      resolve(1'b0, 32'h0);
      n_total++; if (upd_idx !== pc[GHR-1:0]) $display("FAIL q_pop_idx got %h want %h", upd_idx, pc[GHR-1:0]); else n_pass++;
    end
    n_total++; if (q_count !== CW'(4)) $display("FAIL q_half got %0d want 4", q_count); else n_pass++;
    // 1 simultaneous pair at count 4, then 20 more to force pointer wrap
    for (int i = 0; i < 21; i++) begin
      pc = 32'h1000 + 32'(n) * 4; n++;
      set_pred(pc, 1'b0, 32'h0, '0, 2'd1);
      exp_q.push_back(pc);
      pc = exp_q.pop_front();
      res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0;
      do_cycle();
      pred_valid = 1'b0; res_valid = 1'b0;
      n_total++;
      if (q_count !== CW'(4) || upd_idx !== pc[GHR-1:0])
        $display("FAIL q_pair%0d got cnt=%0d idx=%h want 4 %h", i, q_count, upd_idx, pc[GHR-1:0]);
      else n_pass++;
    end
    while (exp_q.size() > 0) begin
      pc = exp_q.pop_front();
      resolve(1'b0, 32'h0);
      n_total++; if (upd_idx !== pc[GHR-1:0]) $display("FAIL q_drain_idx got %h want %h", upd_idx, pc[GHR-1:0]); else n_pass++;
    end
    n_total++; if (q_count !== '0 || res_ready !== 1'b0) $display("FAIL q_empty got cnt=%0d rdy=%b want 0 0", q_count, res_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_correct();
    test_saturation();
    test_direction_mispredict();
    test_target_mispredict();
    test_queue_limits();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
